// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with status flags, occupancy count, sticky error flags, flush and FWFT mode.
// Latency: standard mode gives read data 1 cycle after an accepted read; FWFT shows the head entry combinationally.
// Backpressure: writes are refused while full unless a read is accepted in the same cycle; reads are refused while empty.
module fifo_sync_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       write_en,
  input  logic                       read_en,
  output logic [WIDTH-1:0]           data_out,
  output logic                       rd_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_AF   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] CNT_AE   = CW'(AE_LEVEL);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             rdv_q, rdv_d;

  logic full_w, empty_w;
  logic rd_accept, wr_accept;

  assign full_w  = (count_q == CNT_FULL);
  assign empty_w = (count_q == '0);

  // A full FIFO still takes a write when a read frees a slot in the same cycle; flush blocks both.
  assign rd_accept = !flush && read_en && !empty_w;
  assign wr_accept = !flush && write_en && (!full_w || rd_accept);

  // Next-state for pointers, occupancy, sticky errors and the registered read port.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    dout_d   = dout_q;
    rdv_d    = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
      dout_d   = '0;
    end else begin
      if (wr_accept) begin
        wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      end
      if (rd_accept) begin
        rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        dout_d   = mem_q[rd_ptr_q];
        rdv_d    = 1'b1;
      end
      if (wr_accept && !rd_accept) begin
        count_d = count_q + 1'b1;
      end else if (rd_accept && !wr_accept) begin
        count_d = count_q - 1'b1;
      end
      if (write_en && !wr_accept) begin
        ovf_d = 1'b1;
      end
      if (read_en && empty_w) begin
        unf_d = 1'b1;
      end
    end
  end

  // Control state, cleared asynchronously; storage is deliberately left out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      dout_q   <= '0;
      rdv_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      dout_q   <= dout_d;
      rdv_q    <= rdv_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign full         = full_w;
  assign empty        = empty_w;
  assign almost_full  = (count_q >= CNT_AF);
  assign almost_empty = (count_q <= CNT_AE);
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  // FWFT presents the head entry straight from storage, addressed by the registered read pointer.
  if (FWFT != 0) begin : g_fwft
    assign data_out = empty_w ? '0 : mem_q[rd_ptr_q];
    assign rd_valid = !empty_w;
  end else begin : g_std
    assign data_out = dout_q;
    assign rd_valid = rdv_q;
  end

endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
Parametrised single-clock FIFO. It is the next generation of the team's 8-bit fifo block, generalised in data width and depth. It adds status flags (full/empty, programmable almost-full/almost-empty), an occupancy count, sticky overflow/underflow error flags, a synchronous flush, and a selectable first-word-fall-through (FWFT) read mode. It sits between any producer/consumer pair in the same clock domain.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of storage entries (>=2, any integer, not restricted to powers of two)
AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of contents and error flags
data_in  input  WIDTH  write data
write_en  input  1  write request
read_en  input  1  read request
data_out  output  WIDTH  read data
rd_valid  output  1  data_out holds valid read data
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  $clog2(DEPTH+1)  current occupancy
overflow  output  1  sticky: write attempted while full and not accepted
underflow  output  1  sticky: read attempted while empty

Behaviour:
- Reset: one clock and an asynchronous, active-low reset (clk, rst_n). Reset is applied asynchronously and released synchronously by the system. It clears pointers and count to 0, data_out to 0, rd_valid 0, empty 1, full 0, almost_empty 1, almost_full 0 (unless AF_LEVEL==0), overflow 0, underflow 0. Memory contents are not reset.
- Reset mid-operation discards all stored data. The first post-reset write is stored at entry 0.
- Pointers wrap from DEPTH-1 to 0. The count is separate, so full and empty are never ambiguous.
- Write accept: write_en && (!full || read_accept). Rejected write: contents unchanged, overflow set to 1 on the next edge.
- Read accept: read_en && !empty. Read when empty: no pointer change, underflow set to 1, rd_valid 0.
- Simultaneous accepted write and read: count unchanged, both pointers advance.
  - When full, read and write in the same cycle are both accepted; no overflow is flagged.
  - When empty, the read is an underflow and the write is accepted, giving count 1.
- Standard mode (FWFT=0): an accepted read at edge N gives data_out = head entry and rd_valid = 1 after edge N (latency 1). rd_valid is a single-cycle pulse per accepted read. data_out holds its last value otherwise.
- FWFT mode: data_out shows the head entry combinationally whenever !empty, and rd_valid = !empty. read_en pops the head. A write into an empty FIFO is visible on data_out one cycle after the write edge.
- Flags and count are registered or derived from registered count and update on the same edge as the causing operation.
- Overflow and underflow stay high until rst_n or flush.
- flush (synchronous) has priority over write_en and read_en in the same cycle. It gives the same output state as reset, except the memory contents.
- No combinational path from write_en or read_en to any output, except FWFT data_out via the pointer (registered).

Test Plan:
- Reset then write 0..4 (WIDTH=8, DEPTH=16, FWFT=0), then read 5 -> data_out 0,1,2,3,4 each one cycle after its read_en, rd_valid pulses 5 times, count 5→0, empty=1 at end, no error flags.
- Write 16 words 0x10..0x1F, then a 17th write of 0xAA -> full=1, count=16, overflow=1. Read all 16 -> 0x10..0x1F, 0xAA never appears.
- Fill to full, then read_en and write_en together for 3 cycles with 0xA0..0xA2 -> count stays 16, no overflow. Drain: 0x13..0x1F then 0xA0..0xA2.
- Wrap-around with DEPTH=5: 3 pushes, 3 pops, 5 pushes of 0..4 -> full=1. Pops return 0..4 in order. almost_full first asserts at count 3 (AF_LEVEL=3).
- Read on empty -> underflow=1, rd_valid 0, count 0. Then flush with write_en=1 in the same cycle -> underflow=0, count 0, write dropped.
- FWFT=1: write 0x5A into empty -> data_out=0x5A and rd_valid=1 one cycle later without read_en. read_en pop -> empty=1, rd_valid=0. Assert rst_n=0 while count=3 -> all outputs at reset values immediately.
